// File: rtl/core_clk_rst_seq.sv
// Clock-enable / reset sequencer for one clock domain, driven by SYS_CTRL request levels.
// Optional lock-timeout error path enabled by defining CORE_SEQ_LOCK_TIMEOUT_EN.
module core_clk_rst_seq #(
  parameter int LOCK_STABLE  = 16,
  parameter int RST_DLY      = 8,
  parameter int GATE_DLY     = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       req_clk_en_i,
  input  logic       req_rst_ni,
  input  logic       pll_locked_i,
  output logic       clk_en_o,
  output logic       rst_no,
  output logic [2:0] state_o,
  output logic       busy_o,
  output logic       lock_lost_o,
  output logic       err_o
);

  localparam int MAX_AB  = (LOCK_STABLE > RST_DLY) ? LOCK_STABLE : RST_DLY;
  localparam int MAX_ABC = (MAX_AB > GATE_DLY) ? MAX_AB : GATE_DLY;
  localparam int MAX_ALL = (MAX_ABC > LOCK_TIMEOUT) ? MAX_ABC : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] LS_TERM = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] GD_TERM = CNT_W'(GATE_DLY - 1);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    WAIT_LOCK = 3'd1,
    CLK_ON    = 3'd2,
    RUN       = 3'd3,
    GATE      = 3'd4,
    ERR       = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lost_q, lost_d;
  logic             clk_en_q, rst_n_q;

`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_TERM = CNT_W'(LOCK_TIMEOUT - 1);
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = 1'b0;
`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      OFF: begin
        if (req_clk_en_i) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!req_clk_en_i) begin
          state_d = OFF;
        end else if (pll_locked_i && cnt_q == LS_TERM) begin
          state_d = CLK_ON;
        end else begin
          cnt_d = pll_locked_i ? cnt_q + 1'b1 : '0;
`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
          // Total time in WAIT_LOCK, regardless of lock bouncing.
          if (tcnt_q == TO_TERM) state_d = ERR;
          else                   tcnt_d  = tcnt_q + 1'b1;
`endif
        end
      end
      CLK_ON: begin
        if (!pll_locked_i) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (!req_clk_en_i) begin
          state_d = GATE;
        end else if (req_rst_ni) begin
          if (cnt_q == RD_TERM) state_d = RUN;
          else                  cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      RUN: begin
        if (!pll_locked_i) begin
          state_d = WAIT_LOCK;
          lost_d  = 1'b1;
        end else if (!req_clk_en_i) begin
          state_d = GATE;
        end else if (!req_rst_ni) begin
          state_d = CLK_ON;
        end
      end
      GATE: begin
        // Requests are ignored here; only lock loss cuts the hold short.
        if (!pll_locked_i || cnt_q == GD_TERM) state_d = OFF;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
      ERR: begin
        if (!req_clk_en_i) state_d = OFF;
      end
`endif
      default: state_d = OFF;
    endcase
    if (state_d != state_q) begin
      cnt_d  = '0;
`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
      tcnt_d = '0;
`endif
    end
  end

  // Clock enable and reset are flopped from next state so they never glitch.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
      clk_en_q <= (state_d == CLK_ON) || (state_d == RUN) || (state_d == GATE);
      rst_n_q  <= (state_d == RUN);
    end
  end

`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
  assign err_o = (state_q == ERR);
`else
  assign err_o = 1'b0;
`endif

  assign clk_en_o    = clk_en_q;
  assign rst_no      = rst_n_q;
  assign state_o     = state_q;
  assign lock_lost_o = lost_q;
  assign busy_o      = (state_q == WAIT_LOCK) || (state_q == GATE) ||
                       ((state_q == CLK_ON) && req_rst_ni);

  a_rst_implies_clk: assert property (@(posedge clk_i) disable iff (!arst_ni)
                                      rst_no |-> clk_en_o);

endmodule

// File: tb/tb_core_clk_rst_seq.sv
// Directed-vector bench for core_clk_rst_seq; LOCK_TIMEOUT reduced to 64.
module tb_core_clk_rst_seq;

  logic       clk_i = 1'b0;
  logic       arst_ni;
  logic       req_clk_en_i, req_rst_ni, pll_locked_i;
  logic       clk_en_o, rst_no, busy_o, lock_lost_o, err_o;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  core_clk_rst_seq #(
    .LOCK_STABLE (16),
    .RST_DLY     (8),
    .GATE_DLY    (4),
    .LOCK_TIMEOUT(64)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_clk_en_i(req_clk_en_i),
    .req_rst_ni  (req_rst_ni),
    .pll_locked_i(pll_locked_i),
    .clk_en_o    (clk_en_o),
    .rst_no      (rst_no),
    .state_o     (state_o),
    .busy_o      (busy_o),
    .lock_lost_o (lock_lost_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic ce, input logic rn);
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".clk_en"}, 32'(clk_en_o), 32'(ce));
    chk({tag, ".rst_n"}, 32'(rst_no), 32'(rn));
  endtask

  initial begin
    arst_ni      = 1'b0;
    req_clk_en_i = 1'b0;
    req_rst_ni   = 1'b0;
    pll_locked_i = 1'b0;
    #23;
    chk_out("reset", 3'd0, 1'b0, 1'b0);
    chk("reset.busy", 32'(busy_o), 32'd0);
    chk("reset.lost", 32'(lock_lost_o), 32'd0);
    chk("reset.err", 32'(err_o), 32'd0);
    arst_ni = 1'b1;
    tick(1);

    // Power-up: edge 0 enters WAIT_LOCK, clock at edge 16, reset release at edge 24.
    pll_locked_i = 1'b1; req_clk_en_i = 1'b1; req_rst_ni = 1'b1;
    tick(1);
    chk_out("up.e0", 3'd1, 1'b0, 1'b0);
    chk("up.e0.busy", 32'(busy_o), 32'd1);
    tick(15);
    chk_out("up.e15", 3'd1, 1'b0, 1'b0);
    tick(1);
    chk_out("up.e16", 3'd2, 1'b1, 1'b0);
    chk("up.e16.busy", 32'(busy_o), 32'd1);
    tick(7);
    chk_out("up.e23", 3'd2, 1'b1, 1'b0);
    tick(1);
    chk_out("up.e24", 3'd3, 1'b1, 1'b1);
    chk("up.e24.busy", 32'(busy_o), 32'd0);

    // Power-down: reset drops first, clock gated GATE_DLY edges later.
    req_clk_en_i = 1'b0;
    tick(1);
    chk_out("dn.n", 3'd4, 1'b1, 1'b0);
    chk("dn.n.busy", 32'(busy_o), 32'd1);
    req_clk_en_i = 1'b1;
    tick(3);
    chk_out("dn.n3", 3'd4, 1'b1, 1'b0);
    tick(1);
    chk_out("dn.n4", 3'd0, 1'b0, 1'b0);
    tick(1);
    chk_out("dn.n5", 3'd1, 1'b0, 1'b0);

    // Lock drops after 10 locked cycles; stable count restarts.
    tick(10);
    pll_locked_i = 1'b0;
    tick(1);
    pll_locked_i = 1'b1;
    tick(15);
    chk_out("relk.15", 3'd1, 1'b0, 1'b0);
    tick(1);
    chk_out("relk.16", 3'd2, 1'b1, 1'b0);
    tick(8);
    chk_out("relk.run", 3'd3, 1'b1, 1'b1);

    // Lock loss in RUN.
    pll_locked_i = 1'b0;
    tick(1);
    chk_out("loss", 3'd1, 1'b0, 1'b0);
    chk("loss.pulse", 32'(lock_lost_o), 32'd1);
    pll_locked_i = 1'b1;
    tick(1);
    chk("loss.pulse_end", 32'(lock_lost_o), 32'd0);
    tick(15);
    chk_out("loss.reseq", 3'd2, 1'b1, 1'b0);

    // Reset request held low keeps CLK_ON; RUN falls back to CLK_ON on reset request.
    req_rst_ni = 1'b0;
    tick(20);
    chk_out("hold", 3'd2, 1'b1, 1'b0);
    chk("hold.busy", 32'(busy_o), 32'd0);
    req_rst_ni = 1'b1;
    tick(8);
    chk_out("hold.run", 3'd3, 1'b1, 1'b1);
    req_rst_ni = 1'b0;
    tick(1);
    chk_out("rstreq", 3'd2, 1'b1, 1'b0);

    // Lock loss during GATE goes straight to OFF without a pulse.
    req_clk_en_i = 1'b0;
    tick(1);
    chk_out("glk.gate", 3'd4, 1'b1, 1'b0);
    pll_locked_i = 1'b0;
    tick(1);
    chk_out("glk.off", 3'd0, 1'b0, 1'b0);
    chk("glk.nopulse", 32'(lock_lost_o), 32'd0);

    // Lock never arrives.
    req_clk_en_i = 1'b1; req_rst_ni = 1'b1;
    tick(1);
    tick(63);
    chk_out("to.63", 3'd1, 1'b0, 1'b0);
    chk("to.63.err", 32'(err_o), 32'd0);
    tick(1);
`ifdef CORE_SEQ_LOCK_TIMEOUT_EN
    chk_out("to.64", 3'd5, 1'b0, 1'b0);
    chk("to.64.err", 32'(err_o), 32'd1);
`else
    chk_out("to.64", 3'd1, 1'b0, 1'b0);
    chk("to.64.err", 32'(err_o), 32'd0);
`endif
    req_clk_en_i = 1'b0;
    tick(1);
    chk_out("to.off", 3'd0, 1'b0, 1'b0);
    chk("to.off.err", 32'(err_o), 32'd0);

    // Async reset mid-RUN drops outputs without a clock edge.
    pll_locked_i = 1'b1; req_clk_en_i = 1'b1;
    tick(25);
    chk_out("ar.run", 3'd3, 1'b1, 1'b1);
    #2 arst_ni = 1'b0;
    #1;
    chk_out("ar.drop", 3'd0, 1'b0, 1'b0);
    #3 arst_ni = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
